// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: shares one single-port 2048x32 RAM between the instruction and data masters.
// Optional build macro ONCHIP_MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed data priority.
module onchip_mem_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic                  i_read,
    output logic                  i_waitrequest,
    output logic [DATA_WIDTH-1:0] i_readdata,
    output logic                  i_readdatavalid,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [BE_WIDTH-1:0]   d_byteenable,
    input  logic [DATA_WIDTH-1:0] d_writedata,
    output logic                  d_waitrequest,
    output logic [DATA_WIDTH-1:0] d_readdata,
    output logic                  d_readdatavalid,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BE_WIDTH-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_WIDTH-1:0] mem_readdata
);
    logic                  i_req, d_req, grant_i, grant_d;
    logic                  pend_i_q, pend_i_d, pend_d_q, pend_d_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
`ifdef ONCHIP_MEM_ARB_ROUND_ROBIN_EN
    logic                  last_d_q, last_d_d;
`endif

    // Requests are masked during reset so no grant, waitrequest or RAM access escapes while it is held.
    always_comb begin
        i_req = i_read & ~reset;
        d_req = (d_read | d_write) & ~reset;
`ifdef ONCHIP_MEM_ARB_ROUND_ROBIN_EN
        grant_d  = d_req & (~i_req | ~last_d_q);
        last_d_d = grant_d ? 1'b1 : (i_req ? 1'b0 : last_d_q);
`else
        grant_d  = d_req;
`endif
        grant_i  = i_req & ~grant_d;
        pend_i_d = grant_i;
        pend_d_d = grant_d & d_read & ~d_write;
        addr_d   = grant_i ? i_address : (grant_d ? d_address : addr_q);
        be_d     = grant_i ? {BE_WIDTH{1'b1}} : (grant_d ? d_byteenable : be_q);
        wdata_d  = grant_d ? d_writedata : wdata_q;
    end

    // Drive the RAM port and route returned read data only to the master whose read is pending.
    always_comb begin
        i_waitrequest   = i_req & ~grant_i;
        d_waitrequest   = d_req & ~grant_d;
        mem_chipselect  = grant_i | grant_d;
        mem_write       = grant_d & d_write;
        mem_address     = addr_d;
        mem_byteenable  = be_d;
        mem_writedata   = wdata_d;
        mem_clken       = ~reset;
        i_readdatavalid = pend_i_q;
        d_readdatavalid = pend_d_q;
        i_readdata      = pend_i_q ? mem_readdata : '0;
        d_readdata      = pend_d_q ? mem_readdata : '0;
    end

    // Pending-read flags, held RAM-port values and arbitration history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_i_q <= 1'b0;
            pend_d_q <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
`ifdef ONCHIP_MEM_ARB_ROUND_ROBIN_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            pend_i_q <= pend_i_d;
            pend_d_q <= pend_d_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
`ifdef ONCHIP_MEM_ARB_ROUND_ROBIN_EN
            last_d_q <= last_d_d;
`endif
        end
    end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: scoreboard bench with a RAM model and a transaction-level reference.
module tb_onchip_mem_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic [10:0] i_address = '0, d_address = '0, mem_address;
    logic        i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [3:0]  d_byteenable = '0, mem_byteenable;
    logic [31:0] d_writedata = '0, i_readdata, d_readdata, mem_writedata, mem_readdata = '0;
    logic        i_waitrequest, i_readdatavalid, d_waitrequest, d_readdatavalid;
    logic        mem_chipselect, mem_write, mem_clken;

    onchip_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest),
        .i_readdata(i_readdata), .i_readdatavalid(i_readdatavalid),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_byteenable(d_byteenable), .d_writedata(d_writedata),
        .d_waitrequest(d_waitrequest), .d_readdata(d_readdata), .d_readdatavalid(d_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        iq[$], dq[$];
    logic [31:0] ram [2048];
    logic [31:0] refm[2048];
    int          cyc = 0, n_cmp = 0, n_err = 0;
    logic        ref_last_d = 1'b0, hold_ok = 1'b0;
    logic [10:0] hold_addr = '0;

    function automatic logic [31:0] init_word(input int a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    initial for (int a = 0; a < 2048; a++) begin
        ram[a]  = init_word(a);
        refm[a] = init_word(a);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // The RAM itself: byte-enabled write, registered read, gated by clken and chipselect.
    always @(posedge clk) begin
        logic [31:0] w;
        if (mem_clken && mem_chipselect) begin
            w = ram[mem_address];
            if (mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) w[8*b +: 8] = mem_writedata[8*b +: 8];
            ram[mem_address] <= w;
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expected response whenever a master sees readdatavalid.
    always @(negedge clk) begin
        exp_t e;
        if (i_readdatavalid) begin
            if (iq.size() == 0) chk("i_valid_with_empty_queue", {31'b0, i_readdatavalid}, 32'h0);
            else begin
                e = iq.pop_front();
                chk("i_readdata", i_readdata, e.data);
                chk("i_latency", cyc, e.cyc + 1);
            end
        end else if (i_readdata !== 32'h0) chk("i_readdata_idle", i_readdata, 32'h0);
        if (d_readdatavalid) begin
            if (dq.size() == 0) chk("d_valid_with_empty_queue", {31'b0, d_readdatavalid}, 32'h0);
            else begin
                e = dq.pop_front();
                chk("d_readdata", d_readdata, e.data);
                chk("d_latency", cyc, e.cyc + 1);
            end
        end else if (d_readdata !== 32'h0) chk("d_readdata_idle", d_readdata, 32'h0);
    end

    // One bus cycle: drive requests, predict the arbitration outcome, check the RAM port, queue responses.
    task automatic step(input logic ir, input logic [10:0] ia, input logic dr, input logic dw,
                        input logic [10:0] da, input logic [3:0] be, input logic [31:0] wd,
                        output logic gi, output logic gd);
        exp_t e;
        @(posedge clk);
        #1;
        i_read = ir; i_address = ia;
        d_read = dr; d_write = dw; d_address = da; d_byteenable = be; d_writedata = wd;
        #2;
`ifdef ONCHIP_MEM_ARB_ROUND_ROBIN_EN
        gd = (dr | dw) & (!ir | !ref_last_d);
`else
        gd = dr | dw;
`endif
        gi = ir & !gd;
        chk("i_waitrequest", {31'b0, i_waitrequest}, {31'b0, ir & !gi});
        chk("d_waitrequest", {31'b0, d_waitrequest}, {31'b0, (dr | dw) & !gd});
        chk("mem_chipselect", {31'b0, mem_chipselect}, {31'b0, gi | gd});
        chk("mem_write", {31'b0, mem_write}, {31'b0, gd & dw});
        chk("mem_clken", {31'b0, mem_clken}, 32'h1);
        if (gi) begin
            chk("mem_address_i", {21'b0, mem_address}, {21'b0, ia});
            chk("mem_byteenable_i", {28'b0, mem_byteenable}, 32'hF);
            e.data = refm[ia]; e.cyc = cyc; iq.push_back(e);
            hold_addr = ia; hold_ok = 1'b1; ref_last_d = 1'b0;
        end else if (gd) begin
            chk("mem_address_d", {21'b0, mem_address}, {21'b0, da});
            chk("mem_byteenable_d", {28'b0, mem_byteenable}, {28'b0, be});
            if (dw) begin
                chk("mem_writedata", mem_writedata, wd);
                for (int b = 0; b < 4; b++) if (be[b]) refm[da][8*b +: 8] = wd[8*b +: 8];
            end else begin
                e.data = refm[da]; e.cyc = cyc; dq.push_back(e);
            end
            hold_addr = da; hold_ok = 1'b1; ref_last_d = 1'b1;
        end else if (hold_ok) chk("mem_address_held", {21'b0, mem_address}, {21'b0, hold_addr});
    endtask

    task automatic idle(input int n);
        logic gi, gd;
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, gi, gd);
    endtask

    // Reset while both masters keep requesting: nothing may reach the RAM or the masters.
    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        reset = 1'b1; i_read = 1'b1; d_read = 1'b1; d_write = 1'b0;
        iq.delete(); dq.delete();
        ref_last_d = 1'b0; hold_ok = 1'b0;
        for (int k = 0; k < n; k++) begin
            #2;
            chk("rst_mem_clken", {31'b0, mem_clken}, 32'h0);
            chk("rst_mem_chipselect", {31'b0, mem_chipselect}, 32'h0);
            chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
            chk("rst_valids", {30'b0, i_readdatavalid, d_readdatavalid}, 32'h0);
            chk("rst_waitrequests", {30'b0, i_waitrequest, d_waitrequest}, 32'h0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0; i_read = 1'b0; d_read = 1'b0;
    endtask

    initial begin
        logic        gi, gd, hi, hd, ir, dr, dw;
        logic [10:0] ia, da;
        logic [3:0]  be;
        logic [31:0] wd;
        int          r;
        do_reset(3);
        // Instruction fetch of word 0x010.
        step(1'b1, 11'h010, 1'b0, 1'b0, '0, '0, '0, gi, gd);
        idle(2);
        // Partial write over a known word, then read it back.
        step(1'b0, '0, 1'b0, 1'b1, 11'h7FF, 4'hF, 32'h12345678, gi, gd);
        step(1'b0, '0, 1'b0, 1'b1, 11'h7FF, 4'b0011, 32'hDEADBEEF, gi, gd);
        step(1'b0, '0, 1'b1, 1'b0, 11'h7FF, 4'hF, '0, gi, gd);
        idle(2);
        // Read and write together behave as a write only.
        step(1'b0, '0, 1'b1, 1'b1, 11'h020, 4'hF, 32'hCAFEF00D, gi, gd);
        step(1'b0, '0, 1'b1, 1'b0, 11'h020, 4'hF, '0, gi, gd);
        idle(2);
        // Sustained contention from a fresh reset.
        do_reset(1);
        for (int k = 0; k < 4; k++) step(1'b1, 11'h100 + 11'(k), 1'b1, 1'b0, 11'h200 + 11'(k), 4'hF, '0, gi, gd);
        idle(2);
        // Reset arrives in the cycle after a read was accepted.
        step(1'b1, 11'h033, 1'b0, 1'b0, '0, '0, '0, gi, gd);
        do_reset(2);
        step(1'b0, '0, 1'b1, 1'b0, 11'h033, 4'hF, '0, gi, gd);
        idle(2);
        // Random traffic; a stalled master holds its request until granted.
        hi = 1'b0; hd = 1'b0;
        ir = 1'b0; dr = 1'b0; dw = 1'b0; ia = '0; da = '0; be = '0; wd = '0;
        for (int k = 0; k < 400; k++) begin
            if (!hi) begin
                ir = $urandom_range(0, 99) < 55;
                ia = 11'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 11'h7F0 : 11'h0);
            end
            if (!hd) begin
                r  = $urandom_range(0, 9);
                dr = (r >= 4 && r <= 6) || r == 9;
                dw = r == 7 || r == 8 || r == 9;
                da = 11'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 11'h7F0 : 11'h0);
                be = 4'($urandom_range(0, 15));
                wd = $urandom;
            end
            step(ir, ia, dr, dw, da, be, wd, gi, gd);
            hi = ir & !gi;
            hd = (dr | dw) & !gd;
        end
        idle(3);
        chk("i_queue_drained", iq.size(), 32'h0);
        chk("d_queue_drained", dq.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Shares the single-port on-chip RAM (2048 x 32, byte-enabled, 1-cycle read latency) between the Tiger MIPS instruction-fetch master and data master.
- Each master gets an Avalon-MM style pipelined slave interface with waitrequest and readdatavalid.
- The arbiter grants one master per cycle, drives the RAM port, and routes the returned read data to the master that issued the read.
- Sits between the processor bus masters and the onchip_mem instance.

Parameters:
- ADDR_WIDTH, 11, word address width of the RAM.
- DATA_WIDTH, 32, data width.
- BE_WIDTH, 4, byteenable width (DATA_WIDTH/8).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_address  in  ADDR_WIDTH  instruction-master word address.
- i_read  in  1  instruction read request.
- i_waitrequest  out  1  instruction request not accepted this cycle.
- i_readdata  out  DATA_WIDTH  instruction read data.
- i_readdatavalid  out  1  i_readdata valid.
- d_address  in  ADDR_WIDTH  data-master word address.
- d_read  in  1  data read request.
- d_write  in  1  data write request.
- d_byteenable  in  BE_WIDTH  write/read byte lanes.
- d_writedata  in  DATA_WIDTH  write data.
- d_waitrequest  out  1  data request not accepted this cycle.
- d_readdata  out  DATA_WIDTH  data read data.
- d_readdatavalid  out  1  d_readdata valid.
- mem_address  out  ADDR_WIDTH  RAM address.
- mem_byteenable  out  BE_WIDTH  RAM byte enables.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write.
- mem_writedata  out  DATA_WIDTH  RAM write data.
- mem_clken  out  1  RAM clock enable; 0 while reset is asserted, else 1.
- mem_readdata  in  DATA_WIDTH  RAM read data, valid the cycle after a read is issued.

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on port reset.
- Request definitions: i_req = i_read; d_req = d_read | d_write.
- Grant logic is combinational from the requests and the priority state. At most one of grant_i and grant_d is asserted per cycle.
- Default priority: data master wins on conflict. The loser sees waitrequest=1 and must hold its request.
- Waitrequest: x_waitrequest = x_req & ~grant_x. It is 0 when the master is idle.
- Grant to instruction master:
  - mem_address = i_address; mem_byteenable = all ones.
  - mem_chipselect = 1; mem_write = 0.
- Grant to data master:
  - mem_address = d_address; mem_byteenable = d_byteenable.
  - mem_chipselect = 1; mem_write = d_write; mem_writedata = d_writedata.
- No grant: mem_chipselect = 0, mem_write = 0. Address and data outputs are don't-care but held stable from the last grant.
- d_read and d_write asserted together: treated as a write only. No readdatavalid follows.
- Pending-read tracking:
  - Registered flags pend_i and pend_d are set for one cycle after a granted read.
  - x_readdatavalid = pend_x. x_readdata = mem_readdata when pend_x, else 0.
- Latency:
  - Read accepted in cycle N returns data in cycle N+1.
  - Back-to-back reads from either master are accepted every cycle (throughput 1/cycle).
  - Writes complete in the grant cycle and produce no response.
- Reset values:
  - All waitrequest = 0, readdatavalid = 0, readdata = 0.
  - mem_chipselect = 0, mem_write = 0.
  - pend_i = pend_d = 0; last_grant = instruction (so data wins first in RR mode).
- Reset mid-operation: pending flags are cleared immediately. No readdatavalid is emitted for a read issued before reset.

Optional Feature:
- Macro: ONCHIP_MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A registered last_grant bit is updated on every grant.
  - On conflict, the master not granted last wins.
  - Sustained contention alternates d, i, d, i, ...
- Undefined:
  - Fixed priority, data over instruction.
  - last_grant is not implemented.
  - The instruction master can be starved while d_req stays high.

Test Plan:
- Reset, then i_read=1, i_address=0x010, no d_req. Expect: i_waitrequest=0, mem_address=0x010. Next cycle i_readdatavalid=1 and i_readdata equals RAM word 0x010 (from ROM.mif).
- d_write=1, d_address=0x7FF, d_byteenable=4'b0011, d_writedata=0xDEADBEEF over a word holding 0x12345678. Expect: no readdatavalid; a later d_read of 0x7FF returns 0x1234BEEF.
- i_read and d_read both held high for 4 cycles, no macro:
  - d granted all 4 cycles; i_waitrequest=1 throughout.
  - 4 consecutive d_readdatavalid pulses, each 1 cycle after its accept.
- Same stimulus with ONCHIP_MEM_ARB_ROUND_ROBIN_EN defined. Expect grants d,i,d,i; readdatavalid alternates d,i,d,i with correct data per master.
- d_read and d_write both 1 at address 0x020. Expect: mem_write=1 and no d_readdatavalid the next cycle.
- Assert reset in the cycle after an accepted read. Expect: i_readdatavalid and d_readdatavalid stay 0, mem_chipselect=0, mem_clken=0 during reset; normal operation resumes after release.
